// File: rtl/systolic_matmul_ctrl.sv
// Output-stationary NxN systolic matrix multiplier with input skew lanes, a fixed-length flush
// and a row-at-a-time drain of the accumulator grid over a valid/ready result stream.
module systolic_matmul_ctrl #(
  parameter int N            = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int K_MAX        = 16,
  parameter int SIGNED       = 0,
  localparam int KW = $clog2(K_MAX + 1),
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KW-1:0]                k_len,
  output logic                         busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DATA_WIDTH-1:0]      a_col,
  input  logic [N*DATA_WIDTH-1:0]      b_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*OUTPUT_WIDTH-1:0]    out_row,
  output logic [RW-1:0]                out_row_idx,
  output logic                         out_last,
  output logic                         overflow
);
  localparam int DW  = DATA_WIDTH;
  localparam int OW  = OUTPUT_WIDTH;
  localparam int FW  = $clog2(2 * N);
  localparam int NM1 = (N > 1) ? N - 1 : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  state_t state;

  logic [KW-1:0] k_len_q, beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic fire, start_ok;

  logic [N*DW-1:0]      lane_a, lane_b;
  logic [N-1:0]         lane_av, lane_bv;
  logic [N*NM1*DW-1:0]  pe_a, pe_b;
  logic [N*NM1-1:0]     pe_av, pe_bv;
  logic [N*N-1:0]       pe_ovf;
  logic [N*N*OW-1:0]    acc_flat;

  assign fire     = in_valid && in_ready;
  assign start_ok = (state == IDLE) && start && (k_len != '0) && (k_len <= KW'(K_MAX));

  // Lane g sits behind g+1 register stages, so lane g lags lane 0 by g cycles.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DW-1:0] a_pipe [gi+1];
    logic [DW-1:0] b_pipe [gi+1];
    logic [gi:0]   a_vp, b_vp;
    always_ff @(posedge clk) begin
      if (rst) begin
        a_vp <= '0;
        b_vp <= '0;
        for (int s = 0; s <= gi; s++) begin
          a_pipe[s] <= '0;
          b_pipe[s] <= '0;
        end
      end else begin
        a_pipe[0] <= a_col[gi*DW +: DW];
        b_pipe[0] <= b_row[gi*DW +: DW];
        a_vp[0]   <= fire;
        b_vp[0]   <= fire;
        for (int s = 1; s <= gi; s++) begin
          a_pipe[s] <= a_pipe[s-1];
          b_pipe[s] <= b_pipe[s-1];
          a_vp[s]   <= a_vp[s-1];
          b_vp[s]   <= b_vp[s-1];
        end
      end
    end
    assign lane_a[gi*DW +: DW] = a_pipe[gi];
    assign lane_b[gi*DW +: DW] = b_pipe[gi];
    assign lane_av[gi] = a_vp[gi];
    assign lane_bv[gi] = b_vp[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pe
      logic [DW-1:0]   a_in, b_in;
      logic            av_in, bv_in;
      logic [2*DW-1:0] prod;
      logic [OW-1:0]   prod_ext, acc;
      logic [OW:0]     sum;
      logic            sovf;

      if (gj == 0) begin : g_a_edge
        assign a_in  = lane_a[gi*DW +: DW];
        assign av_in = lane_av[gi];
      end else begin : g_a_int
        assign a_in  = pe_a[(gi*NM1 + gj - 1)*DW +: DW];
        assign av_in = pe_av[gi*NM1 + gj - 1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in  = lane_b[gj*DW +: DW];
        assign bv_in = lane_bv[gj];
      end else begin : g_b_int
        assign b_in  = pe_b[((gi-1)*N + gj)*DW +: DW];
        assign bv_in = pe_bv[(gi-1)*N + gj];
      end

      if (SIGNED != 0) begin : g_smul
        assign prod     = (2*DW)'($signed(a_in)) * (2*DW)'($signed(b_in));
        assign prod_ext = OW'($signed(prod));
      end else begin : g_umul
        assign prod     = (2*DW)'(a_in) * (2*DW)'(b_in);
        assign prod_ext = OW'(prod);
      end

      // Carry-out for unsigned, like-signed operands changing sign for signed.
      assign sum  = {1'b0, acc} + {1'b0, prod_ext};
      assign sovf = (acc[OW-1] == prod_ext[OW-1]) && (sum[OW-1] != acc[OW-1]);
      assign pe_ovf[gi*N + gj] = av_in && bv_in && ((SIGNED != 0) ? sovf : sum[OW]);
      assign acc_flat[(gi*N + gj)*OW +: OW] = acc;

      always_ff @(posedge clk) begin
        if (rst || start_ok) begin
          acc <= '0;
        end else if (av_in && bv_in) begin
          acc <= sum[OW-1:0];
        end
      end

      if (gj < N - 1) begin : g_fwd_a
        always_ff @(posedge clk) begin
          if (rst) begin
            pe_a[(gi*NM1 + gj)*DW +: DW] <= '0;
            pe_av[gi*NM1 + gj]           <= 1'b0;
          end else begin
            pe_a[(gi*NM1 + gj)*DW +: DW] <= a_in;
            pe_av[gi*NM1 + gj]           <= av_in;
          end
        end
      end
      if (gi < N - 1) begin : g_fwd_b
        always_ff @(posedge clk) begin
          if (rst) begin
            pe_b[(gi*N + gj)*DW +: DW] <= '0;
            pe_bv[gi*N + gj]           <= 1'b0;
          end else begin
            pe_b[(gi*N + gj)*DW +: DW] <= b_in;
            pe_bv[gi*N + gj]           <= bv_in;
          end
        end
      end
    end
  end

  for (genvar gj = 0; gj < N; gj++) begin : g_out
    assign out_row[gj*OW +: OW] = acc_flat[(int'(out_row_idx)*N + gj)*OW +: OW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k_len_q     <= '0;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_row_idx <= '0;
      out_last    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (start_ok) begin
        overflow <= 1'b0;
      end else if (|pe_ovf) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= LOAD;
            k_len_q  <= k_len;
            beat_cnt <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == k_len_q - 1'b1) begin
              state     <= FLUSH;
              in_ready  <= 1'b0;
              flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          // 2N-1 cycles: N-1 skew + N-1 hops + 1 registered accumulate.
          if (flush_cnt == FW'(2*N - 2)) begin
            state       <= DRAIN;
            out_valid   <= 1'b1;
            out_row_idx <= '0;
            out_last    <= (N == 1);
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_row_idx == RW'(N - 1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_row_idx <= out_row_idx + 1'b1;
              out_last    <= (out_row_idx + 1'b1 == RW'(N - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_matmul_ctrl.sv
// Bench for systolic_matmul_ctrl: unsigned and signed instances share stimulus; a matrix-level
// model predicts handshakes, timing, rows and overflow every cycle, plus literal checks per test.
module tb_systolic_matmul_ctrl;
  localparam int N = 4, DW = 8, OW = 16, KW = 5;

  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [KW-1:0] k_len = '0;
  logic [N*DW-1:0] a_col = '0, b_row = '0;
  logic busy0, in_ready0, out_valid0, last0, ovf0;
  logic busy1, in_ready1, out_valid1, last1, ovf1;
  logic [N*OW-1:0] row0, row1;
  logic [1:0] idx0, idx1;

  systolic_matmul_ctrl #(.N(N), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .K_MAX(16), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy0),
    .in_valid(in_valid), .in_ready(in_ready0), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid0), .out_ready(out_ready), .out_row(row0),
    .out_row_idx(idx0), .out_last(last0), .overflow(ovf0));
  systolic_matmul_ctrl #(.N(N), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .K_MAX(16), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy1),
    .in_valid(in_valid), .in_ready(in_ready1), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid1), .out_ready(out_ready), .out_row(row1),
    .out_row_idx(idx1), .out_last(last1), .overflow(ovf1));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stimulus matrices: am[k][i] = A[i][k], bm[k][j] = B[k][j]
  logic [DW-1:0] am [16][N];
  logic [DW-1:0] bm [16][N];

  // Model state (owned by the monitor)
  bit mon_en = 0, mbusy = 0, movf0 = 0, movf1 = 0;
  int mk = 0, mbeats = 0, last_cyc = 0, cyc = 0, exp_row = 0;
  logic [DW-1:0] ma [16][N];
  logic [DW-1:0] mb [16][N];
  logic [OW-1:0] exp0 [N][N];
  logic [OW-1:0] exp1 [N][N];
  logic [63:0] cap0 [N];
  logic [63:0] cap1 [N];
  int seen [N];

  function automatic logic [63:0] pack_row(input bit sgn, input int r);
    logic [63:0] v = '0;
    for (int j = 0; j < N; j++) v[j*OW +: OW] = sgn ? exp1[r][j] : exp0[r][j];
    return v;
  endfunction

  task automatic compute_model();
    movf0 = 0; movf1 = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int u, s, au, bu, as, bs;
        u = 0; s = 0;
        for (int k = 0; k < mk; k++) begin
          au = int'(ma[k][i]); bu = int'(mb[k][j]);
          as = (au >= 128) ? au - 256 : au;
          bs = (bu >= 128) ? bu - 256 : bu;
          u = u + au * bu;
          if (u >= 65536) begin movf0 = 1; u = u - 65536; end
          s = s + as * bs;
          if (s > 32767) begin movf1 = 1; s = s - 65536; end
          else if (s < -32768) begin movf1 = 1; s = s + 65536; end
        end
        exp0[i][j] = u[15:0];
        exp1[i][j] = s[15:0];
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_rdy, exp_ov;
      cyc++;
      exp_rdy = mbusy && (mbeats < mk);
      exp_ov  = mbusy && (mbeats == mk) && (cyc >= last_cyc + 2*N);
      chk("busy0", 64'(busy0), 64'(mbusy));
      chk("busy1", 64'(busy1), 64'(mbusy));
      chk("in_ready0", 64'(in_ready0), 64'(exp_rdy));
      chk("in_ready1", 64'(in_ready1), 64'(exp_rdy));
      chk("out_valid0", 64'(out_valid0), 64'(exp_ov));
      chk("out_valid1", 64'(out_valid1), 64'(exp_ov));
      if (exp_ov) begin
        chk("row_u", row0, pack_row(0, exp_row));
        chk("row_s", row1, pack_row(1, exp_row));
        chk("row_idx0", 64'(idx0), 64'(exp_row));
        chk("row_idx1", 64'(idx1), 64'(exp_row));
        chk("last0", 64'(last0), 64'(exp_row == N-1));
        chk("last1", 64'(last1), 64'(exp_row == N-1));
        chk("drain_ovf0", 64'(ovf0), 64'(movf0));
        chk("drain_ovf1", 64'(ovf1), 64'(movf1));
      end
      if (!mbusy) begin
        chk("idle_ovf0", 64'(ovf0), 64'(movf0));
        chk("idle_ovf1", 64'(ovf1), 64'(movf1));
      end
      if (rst) begin
        mbusy = 0; movf0 = 0; movf1 = 0;
      end else begin
        if (exp_ov && out_ready) begin
          cap0[exp_row] = row0;
          cap1[exp_row] = row1;
          seen[exp_row]++;
          if (exp_row == N-1) mbusy = 0;
          else exp_row++;
        end else if (!mbusy && start && k_len != 0 && k_len <= 16) begin
          mbusy = 1; mk = int'(k_len); mbeats = 0; exp_row = 0;
          movf0 = 0; movf1 = 0;
        end
        if (exp_rdy && in_valid) begin
          for (int e = 0; e < N; e++) begin
            ma[mbeats][e] = a_col[e*DW +: DW];
            mb[mbeats][e] = b_row[e*DW +: DW];
          end
          mbeats++;
          if (mbeats == mk) begin
            last_cyc = cyc;
            compute_model();
          end
        end
      end
    end
  end

  task automatic clear_seen();
    for (int r = 0; r < N; r++) begin seen[r] = 0; cap0[r] = '0; cap1[r] = '0; end
  endtask

  task automatic run_job(input int k, input bit toggle, input bit stall);
    int idx, guard, stall_left;
    bit fire, done;
    clear_seen();
    @(posedge clk); #1 start = 1; k_len = KW'(k);
    @(posedge clk); #1 start = 0;
    idx = 0; guard = 0;
    while (idx < k && guard < 200) begin
      in_valid = toggle ? ~in_valid : 1'b1;
      for (int e = 0; e < N; e++) begin
        a_col[e*DW +: DW] = am[idx][e];
        b_row[e*DW +: DW] = bm[idx][e];
      end
      fire = in_valid && in_ready0;
      @(posedge clk); #1;
      if (fire) idx++;
      guard++;
    end
    in_valid = 0;
    if (guard >= 200) chk("load_timeout", 64'(idx), 64'(k));
    stall_left = stall ? 3 : 0; done = 0; guard = 0;
    while (!done && guard < 200) begin
      if (stall_left > 0 && out_valid0 && idx0 == 2'd1) begin
        out_ready = 0; stall_left--;
      end else begin
        out_ready = 1;
      end
      done = out_valid0 && out_ready && last0;
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 0;
    if (!done) chk("drain_timeout", 64'(done), 64'd1);
  endtask

  task automatic set_test1();
    for (int k = 0; k < 4; k++)
      for (int e = 0; e < N; e++) begin
        am[k][e] = (k == e) ? 8'd1 : 8'd0;
        bm[k][e] = 8'(4*k + e + 1);
      end
  endtask

  task automatic check_test1(input string tag);
    for (int r = 0; r < N; r++) begin
      logic [63:0] lit;
      for (int j = 0; j < N; j++) lit[j*OW +: OW] = 16'(4*r + j + 1);
      chk({tag, "_row_u"}, cap0[r], lit);
      chk({tag, "_row_s"}, cap1[r], lit);
      chk({tag, "_seen"}, 64'(seen[r]), 64'd1);
    end
    chk({tag, "_ovf0"}, 64'(ovf0), 64'd0);
  endtask

  task automatic set_fill(input logic [7:0] av, input logic [7:0] bv);
    for (int k = 0; k < 16; k++)
      for (int e = 0; e < N; e++) begin am[k][e] = av; bm[k][e] = bv; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    mon_en = 1;
    chk("reset_busy", 64'(busy0), 64'd0);
    chk("reset_in_ready", 64'(in_ready0), 64'd0);
    chk("reset_out_valid", 64'(out_valid0), 64'd0);
    chk("reset_row", row0, 64'd0);
    chk("reset_idx", 64'(idx0), 64'd0);
    chk("reset_last", 64'(last0), 64'd0);
    chk("reset_ovf", 64'(ovf1), 64'd0);

    // 1: identity A, streaming
    set_test1();
    run_job(4, 0, 0);
    check_test1("t1");
    // 2: in_valid toggling
    run_job(4, 1, 0);
    check_test1("t2");
    // 3: back-pressure on row 1
    run_job(4, 0, 1);
    check_test1("t3");

    // 4: unsigned wrap, k=2
    set_fill(8'hFF, 8'hFF);
    run_job(2, 0, 0);
    for (int r = 0; r < N; r++) begin
      chk("t4_row_u", cap0[r], {4{16'd64514}});
      chk("t4_row_s", cap1[r], {4{16'd2}});
    end
    repeat (3) @(posedge clk);
    #1 chk("t4_ovf0_held", 64'(ovf0), 64'd1);
    chk("t4_ovf1", 64'(ovf1), 64'd0);

    // 5: signed -128*127, k=1; start clears the earlier overflow
    set_fill(8'h80, 8'h7F);
    run_job(1, 0, 0);
    for (int r = 0; r < N; r++) begin
      chk("t5_row_s", cap1[r], {4{16'hC080}});
      chk("t5_row_u", cap0[r], {4{16'h3F80}});
    end
    chk("t5_ovf0", 64'(ovf0), 64'd0);
    chk("t5_ovf1", 64'(ovf1), 64'd0);

    // 6: reset mid-load, then illegal starts, then a clean job
    set_test1();
    @(posedge clk); #1 start = 1; k_len = 5'd4;
    @(posedge clk); #1 start = 0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1;
      for (int e = 0; e < N; e++) begin
        a_col[e*DW +: DW] = am[b][e];
        b_row[e*DW +: DW] = bm[b][e];
      end
      @(posedge clk); #1;
    end
    in_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (12) @(posedge clk);
    #1 chk("t6_busy", 64'(busy0), 64'd0);
    chk("t6_out_valid", 64'(out_valid0), 64'd0);
    start = 1; k_len = 5'd0;
    @(posedge clk); #1 k_len = 5'd17;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 chk("t6_bad_start_busy", 64'(busy0), 64'd0);
    chk("t6_bad_start_ready", 64'(in_ready1), 64'd0);
    run_job(4, 0, 0);
    check_test1("t6");

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
